// File: rtl/mux_nto1_scan_reg.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1_scan_reg
// Description : Registered N:1 multiplexer of WIDTH-bit channels with a
//               valid/ready output and manual or round-robin scan selection.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nto1_scan_reg #(
    parameter int WIDTH = 8,
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               in_valid,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    input  logic [N-1:0]       ch_en,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               out_err
);

    typedef enum logic [0:0] {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_ch;
    logic             r_valid;
    logic             r_last;
    logic             r_err;

    logic [WIDTH-1:0] w_chan [N];
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_oor;
    logic [SEL_W-1:0] w_base;
    logic             w_found_hi;
    logic [SEL_W-1:0] w_cap_hi;
    logic [SEL_W-1:0] w_cap_lo;
    logic [SEL_W-1:0] w_cap;
    logic             w_scan_last;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic             w_free;
    logic             w_load_man;
    logic             w_load_scan;

    for (genvar g = 0; g < N; g++) begin : g_chan
        assign w_chan[g] = in_data[g*WIDTH +: WIDTH];
    end

    // Out-of-range selects (possible when N is not a power of 2) yield zero data.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(sel) == k) begin
                w_sel_data = w_chan[k];
            end
        end
    end

    assign w_sel_oor = (int'(sel) >= N);

    // Entering scan restarts the sweep from channel 0 in the same cycle.
    assign w_base = (r_state == ST_SCAN) ? r_ptr : '0;

    // Lowest enabled channel at/above the base wins; otherwise wrap to lowest overall.
    always_comb begin
        w_found_hi = 1'b0;
        w_cap_hi   = '0;
        w_cap_lo   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (ch_en[k]) begin
                w_cap_lo = SEL_W'(k);
                if (k >= int'(w_base)) begin
                    w_found_hi = 1'b1;
                    w_cap_hi   = SEL_W'(k);
                end
            end
        end
    end

    assign w_cap = w_found_hi ? w_cap_hi : w_cap_lo;

    always_comb begin
        w_scan_last = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (ch_en[k] && (k > int'(w_cap))) begin
                w_scan_last = 1'b0;
            end
        end
    end

    assign w_ptr_nxt   = (w_cap == c_last_ch) ? '0 : w_cap + SEL_W'(1);
    assign w_free      = !r_valid || out_ready;
    assign w_load_man  = !mode && in_valid && w_free;
    assign w_load_scan = mode && in_valid && w_free && (|ch_en);

    always_comb begin
        w_state_nxt = ST_MANUAL;
        if (mode) begin
            w_state_nxt = ST_SCAN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_MANUAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_load_man) begin
                r_data  <= w_sel_data;
                r_ch    <= sel;
                r_err   <= w_sel_oor;
                r_last  <= 1'b0;
                r_valid <= 1'b1;
            end else if (w_load_scan) begin
                r_data  <= w_chan[w_cap];
                r_ch    <= w_cap;
                r_err   <= 1'b0;
                r_last  <= w_scan_last;
                r_valid <= 1'b1;
            end else if (w_free) begin
                r_valid <= 1'b0;
            end

            if (w_load_scan) begin
                r_ptr <= w_ptr_nxt;
            end else if ((r_state == ST_MANUAL) && mode) begin
                r_ptr <= '0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_scan_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_nto1_scan_reg
// Description : Directed-vector bench for mux_nto1_scan_reg (N=16 and N=12).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nto1_scan_reg;

    logic         clk;
    logic         rst;

    logic [127:0] in_data;
    logic         in_valid;
    logic [3:0]   sel;
    logic         mode;
    logic [15:0]  ch_en;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [3:0]   out_ch;
    logic         out_valid;
    logic         out_last;
    logic         out_err;

    logic [95:0]  in_data12;
    logic         in_valid12;
    logic [3:0]   sel12;
    logic         mode12;
    logic [11:0]  ch_en12;
    logic         out_ready12;
    logic [7:0]   out_data12;
    logic [3:0]   out_ch12;
    logic         out_valid12;
    logic         out_last12;
    logic         out_err12;

    int total;
    int bad;

    mux_nto1_scan_reg #(.WIDTH(8), .N(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .sel(sel), .mode(mode), .ch_en(ch_en), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_err(out_err)
    );

    mux_nto1_scan_reg #(.WIDTH(8), .N(12)) dut12 (
        .clk(clk), .rst(rst), .in_data(in_data12), .in_valid(in_valid12),
        .sel(sel12), .mode(mode12), .ch_en(ch_en12), .out_data(out_data12),
        .out_ch(out_ch12), .out_valid(out_valid12), .out_ready(out_ready12),
        .out_last(out_last12), .out_err(out_err12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  sel;
        logic        mode;
        logic        iv;
        logic        rdy;
        logic [15:0] en;
        logic        ev;
        logic [3:0]  ech;
        logic [7:0]  edat;
        logic        elast;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];

    // Packed view {valid, last, err, ch, data}
    function automatic logic [14:0] pk(input logic v, input logic l, input logic e,
                                       input logic [3:0] c, input logic [7:0] d);
        return {v, l, e, c, d};
    endfunction

    task automatic chk(input string nm, input logic [14:0] got, input logic [14:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] s, input logic m, input logic iv,
                                input logic rdy, input logic [15:0] en, input logic ev,
                                input logic [3:0] ech, input logic [7:0] edat,
                                input logic elast, input logic eerr);
        vec_t v;
        v.sel = s; v.mode = m; v.iv = iv; v.rdy = rdy; v.en = en;
        v.ev = ev; v.ech = ech; v.edat = edat; v.elast = elast; v.eerr = eerr;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        sel = v.sel; mode = v.mode; in_valid = v.iv; out_ready = v.rdy; ch_en = v.en;
        step();
        if (v.ev)
            chk(nm, pk(out_valid, out_last, out_err, out_ch, out_data),
                pk(1'b1, v.elast, v.eerr, v.ech, v.edat));
        else
            chk(nm, {14'd0, out_valid}, 15'd0);
    endtask

    task automatic run12(input logic [3:0] s, input logic m, input logic [11:0] en,
                         input logic [14:0] exp, input string nm);
        sel12 = s; mode12 = m; ch_en12 = en; in_valid12 = 1'b1; out_ready12 = 1'b1;
        step();
        chk(nm, pk(out_valid12, out_last12, out_err12, out_ch12, out_data12), exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int k = 0; k < 16; k++) in_data[k*8 +: 8] = 8'(16 + k);
        for (int k = 0; k < 12; k++) in_data12[k*8 +: 8] = 8'(16 + k);
        in_valid = 0; sel = 0; mode = 0; ch_en = 0; out_ready = 1;
        in_valid12 = 0; sel12 = 0; mode12 = 0; ch_en12 = 0; out_ready12 = 1;

        // Vector table
        for (int k = 0; k < 16; k++)
            tbl.push_back(mk(4'(k), 0, 1, 1, 16'h0, 1, 4'(k), 8'(16 + k), 0, 0));
        tbl.push_back(mk(4'd5, 0, 1, 1, 16'h0, 1, 4'd5, 8'h15, 0, 0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(4'd9, 0, 1, 0, 16'h0, 1, 4'd5, 8'h15, 0, 0));
        tbl.push_back(mk(4'd9, 0, 1, 1, 16'h0, 1, 4'd9, 8'h19, 0, 0));
        tbl.push_back(mk(4'd0, 1, 1, 1, 16'h8025, 1, 4'd0,  8'h10, 0, 0));
        tbl.push_back(mk(4'd0, 1, 1, 1, 16'h8025, 1, 4'd2,  8'h12, 0, 0));
        tbl.push_back(mk(4'd0, 1, 1, 1, 16'h8025, 1, 4'd5,  8'h15, 0, 0));
        tbl.push_back(mk(4'd0, 1, 1, 1, 16'h8025, 1, 4'd15, 8'h1F, 1, 0));
        tbl.push_back(mk(4'd0, 1, 1, 1, 16'h8025, 1, 4'd0,  8'h10, 0, 0));
        tbl.push_back(mk(4'd0, 1, 1, 1, 16'h8025, 1, 4'd2,  8'h12, 0, 0));
        // mode 1 -> 0 -> 1 restarts the sweep at channel 0
        tbl.push_back(mk(4'd7, 0, 1, 1, 16'h8025, 1, 4'd7,  8'h17, 0, 0));
        tbl.push_back(mk(4'd0, 1, 1, 1, 16'h8025, 1, 4'd0,  8'h10, 0, 0));
        tbl.push_back(mk(4'd0, 1, 1, 1, 16'h8025, 1, 4'd2,  8'h12, 0, 0));
        // scan stall: pointer must not advance
        tbl.push_back(mk(4'd0, 1, 1, 0, 16'h8025, 1, 4'd2,  8'h12, 0, 0));
        tbl.push_back(mk(4'd0, 1, 1, 0, 16'h8025, 1, 4'd2,  8'h12, 0, 0));
        tbl.push_back(mk(4'd0, 1, 1, 1, 16'h8025, 1, 4'd5,  8'h15, 0, 0));
        // empty mask
        tbl.push_back(mk(4'd0, 1, 1, 0, 16'h0000, 1, 4'd5,  8'h15, 0, 0));
        tbl.push_back(mk(4'd0, 1, 1, 1, 16'h0000, 0, 4'd0,  8'h00, 0, 0));
        tbl.push_back(mk(4'd0, 1, 1, 1, 16'h0000, 0, 4'd0,  8'h00, 0, 0));
        tbl.push_back(mk(4'd0, 1, 1, 1, 16'h8025, 1, 4'd15, 8'h1F, 1, 0));
        tbl.push_back(mk(4'd0, 1, 1, 1, 16'h8025, 1, 4'd0,  8'h10, 0, 0));
        tbl.push_back(mk(4'd3, 0, 0, 1, 16'h8025, 0, 4'd0,  8'h00, 0, 0));

        #2;
        chk("reset16", pk(out_valid, out_last, out_err, out_ch, out_data), 15'd0);
        chk("reset12", pk(out_valid12, out_last12, out_err12, out_ch12, out_data12), 15'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("idle0", {14'd0, out_valid}, 15'd0);
        step();
        chk("idle1", {14'd0, out_valid}, 15'd0);

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // N=12: out-of-range select and wrap at N-1
        run12(4'd13, 0, 12'h000, pk(1, 0, 1, 4'd13, 8'h00), "oor13");
        run12(4'd3,  0, 12'h000, pk(1, 0, 0, 4'd3,  8'h13), "n12_sel3");
        run12(4'd11, 0, 12'h000, pk(1, 0, 0, 4'd11, 8'h1B), "n12_sel11");
        run12(4'd12, 0, 12'h000, pk(1, 0, 1, 4'd12, 8'h00), "oor12");
        run12(4'd0,  1, 12'h801, pk(1, 0, 0, 4'd0,  8'h10), "n12_scan0");
        run12(4'd0,  1, 12'h801, pk(1, 1, 0, 4'd11, 8'h1B), "n12_scan11");
        run12(4'd0,  1, 12'h801, pk(1, 0, 0, 4'd0,  8'h10), "n12_wrap0");
        in_valid12 = 0;

        // Asynchronous reset while a beat is held
        sel = 4'd4; mode = 0; in_valid = 1; out_ready = 0;
        step();
        chk("held4", pk(out_valid, out_last, out_err, out_ch, out_data),
            pk(1, 0, 0, 4'd4, 8'h14));
        #2 rst = 1'b1;
        #1;
        chk("async_rst", pk(out_valid, out_last, out_err, out_ch, out_data), 15'd0);
        #1 rst = 1'b0;
        in_valid = 0; out_ready = 1;
        step();
        chk("post_rst0", {14'd0, out_valid}, 15'd0);
        step();
        chk("post_rst1", {14'd0, out_valid}, 15'd0);
        sel = 4'd1; in_valid = 1;
        step();
        chk("post_rst_load", pk(out_valid, out_last, out_err, out_ch, out_data),
            pk(1, 0, 0, 4'd1, 8'h11));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_nto1_scan_reg.md
Name: mux_nto1_scan_reg

Overview:
- Parametrised, registered N:1 multiplexer of WIDTH-bit channels with a valid/ready output handshake.
- Two modes: manual (external select) and scan (internal round-robin pointer over a channel-enable mask).
- Used where a multi-channel bus must be serialised onto one downstream consumer that may stall.
- Output is a single holding register, so a selected word is never lost under backpressure.

Parameters:
- WIDTH, 8, bits per channel.
- N, 16, number of input channels (N >= 2; need not be a power of 2).
- SEL_W, $clog2(N), width of select, pointer and channel-index fields.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  packed channels; channel k = in_data[k*WIDTH +: WIDTH].
- in_valid  input  1  in_data (and sel in manual mode) qualified this cycle.
- sel  input  SEL_W  manual-mode channel select.
- mode  input  1  0 = manual, 1 = scan.
- ch_en  input  N  scan-mode channel enable mask.
- out_data  output  WIDTH  registered selected word.
- out_ch  output  SEL_W  channel index of out_data.
- out_valid  output  1  out_data/out_ch/out_last/out_err valid.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
- out_last  output  1  beat is the last enabled channel of a scan sweep (scan mode only).
- out_err  output  1  beat came from an out-of-range manual select.

Behaviour:
- Reset (async, immediate): out_data = 0, out_ch = 0, out_valid = 0, out_last = 0, out_err = 0, ptr = 0, state = MANUAL. Reset mid-beat discards the held beat.
- State register: MANUAL / SCAN, next state = mode each cycle.
  - MANUAL -> SCAN clears ptr to 0 on that edge.
  - SCAN -> MANUAL leaves ptr unchanged (don't care).
  - Mode is sampled in the same cycle as the load decision.
- Slot free: free = !out_valid || out_ready, so a same-cycle pop and reload is allowed for full throughput.
- Manual load:
  - Condition: state/mode manual && in_valid && free.
  - Captures out_data = channel sel, out_ch = sel, out_err = 0, out_last = 0, out_valid = 1.
  - If sel >= N: out_data = 0, out_ch = sel, out_err = 1; the beat is still emitted.
- Scan capture channel: cap = first k with ch_en[k] = 1, searching ptr, ptr+1, … N-1, 0, … ptr-1 (wrap).
- Scan load:
  - Condition: mode scan && in_valid && free && |ch_en.
  - Captures channel cap: out_ch = cap, out_err = 0, out_valid = 1.
  - out_last = 1 iff no ch_en bit above cap.
  - ptr <= (cap == N-1) ? 0 : cap + 1.
- ch_en all zero in scan mode: no load; out_valid falls once the held beat is popped.
- ch_en changes take effect at the next search; no beat already held is altered.
- No load while free = 1: out_valid <= 0. Data, ch, last and err hold their values (don't care).
- While out_valid && !out_ready: all outputs hold stable; ptr does not advance; in_data is not sampled.
- Latency: 1 clk from accepted in_valid to out_valid. Throughput: 1 beat/clk with out_ready held high.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with out_valid = 1 -> all outputs 0 before next edge; after release, out_valid stays 0 until in_valid.
- Manual sweep: WIDTH = 8, N = 16, channel k = 8'h10+k, out_ready = 1, sel = 0..15 one per cycle -> out_data 8'h10..8'h1F with out_ch = sel, one cycle later each, no gaps.
- Backpressure: manual sel = 5, out_ready = 0 for 4 cycles while sel changes to 9 -> out_data stays 8'h15, out_ch = 5; on out_ready = 1 that cycle pops 8'h15 and loads 8'h19 the same edge.
- Scan with mask: ch_en = 16'h8025, in_valid = 1, out_ready = 1 -> out_ch sequence 0, 2, 5, 15, 0, 2 …; out_last = 1 only on ch 15.
- Scan edge cases:
  - ch_en = 0 -> out_valid drops after the held beat.
  - Switching mode 0 -> 1 mid-stream restarts the sweep at the lowest enabled channel.
- Out-of-range (N = 12, SEL_W = 4): sel = 13 -> out_data = 0, out_ch = 13, out_err = 1. Next beat with sel = 3 -> out_err = 0.
